// File: rtl/mem_arbiter.sv
// Arbitrates the unified single-port memory between the instruction-fetch port
// and the data port, with a req/ack handshake, done pulses and a wait timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        last_d;
  logic [7:0]  wait_cnt;
  logic        grant_d, grant_i, ack_done, abort;

  // A done pulse in IDLE blocks granting for one cycle so requesters can turn around.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    ack_done   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (!(i_done || d_done)) begin
          if (d_req && (!last_d || !i_req)) begin
            grant_d    = 1'b1;
            state_next = DATA;
          end else if (i_req) begin
            grant_i    = 1'b1;
            state_next = INST;
          end
        end
      end
      DATA, INST: begin
        if (m_ack) begin
          ack_done   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_d   <= 1'b0;
      wait_cnt <= 8'd0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= 4'h0;
      m_addr   <= 32'h0;
      m_wdata  <= 32'h0;
      i_rdata  <= 32'h0;
      d_rdata  <= 32'h0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      err      <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      if (grant_d) begin
        m_req    <= 1'b1;
        m_we     <= d_we;
        m_be     <= d_be;
        m_addr   <= d_addr;
        m_wdata  <= d_wdata;
        wait_cnt <= 8'd0;
      end else if (grant_i) begin
        m_req    <= 1'b1;
        m_we     <= 1'b0;
        m_be     <= 4'hF;
        m_addr   <= i_addr;
        m_wdata  <= 32'h0;
        wait_cnt <= 8'd0;
      end else if (ack_done || abort) begin
        m_req  <= 1'b0;
        err    <= abort;
        last_d <= (state == DATA);
        // An aborted transaction returns zero; a completed store leaves d_rdata alone.
        if (state == DATA) begin
          d_done <= 1'b1;
          if (abort)      d_rdata <= 32'h0;
          else if (!m_we) d_rdata <= m_rdata;
        end else begin
          i_done  <= 1'b1;
          i_rdata <= abort ? 32'h0 : m_rdata;
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory with programmable
// latency, a completion scoreboard, table-driven traffic and hand-written corner cases.
module tb_mem_arbiter;

  logic        clk, rstn;
  logic        i_req, i_done, i_stall;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done, d_stall;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack, err;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n_d;
    int          n_i;
    bit          d_we;
    logic [3:0]  d_be;
    logic [31:0] d_base;
    logic [31:0] wbase;
    logic [31:0] i_base;
    int          lat;
  } vec_t;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  vec_t vecs[7];

  logic [31:0] mem [logic [31:0]];
  int          mem_lat = 0;
  bit          mem_never = 1'b0;
  bit          mem_spurious = 1'b0;
  logic [31:0] last_ack_addr, last_ack_wdata;
  logic [3:0]  last_ack_be;
  logic        last_ack_we;

  bit          model_last_d = 1'b0;
  logic [31:0] model_d_rdata = 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a ^ 32'hA5C3_0000) + 32'h0000_1111;
  endfunction

  function automatic vec_t make_vec(input int nd, input int ni, input bit we, input logic [3:0] be,
                                    input logic [31:0] db, input logic [31:0] wb,
                                    input logic [31:0] ib, input int lat);
    vec_t v;
    v.n_d = nd; v.n_i = ni; v.d_we = we; v.d_be = be;
    v.d_base = db; v.wbase = wb; v.i_base = ib; v.lat = lat;
    return v;
  endfunction

  function automatic exp_t d_entry(input bit we, input logic [3:0] be,
                                   input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.is_d = 1'b1; e.we = we; e.be = be; e.addr = a; e.wdata = wd; e.err = 1'b0;
    if (!we) model_d_rdata = mem_peek(a);
    e.rdata = model_d_rdata;
    model_last_d = 1'b1;
    return e;
  endfunction

  function automatic exp_t i_entry(input logic [31:0] a);
    exp_t e;
    e.is_d = 1'b0; e.we = 1'b0; e.be = 4'hF; e.addr = a; e.wdata = 32'h0; e.err = 1'b0;
    e.rdata = mem_peek(a);
    model_last_d = 1'b0;
    return e;
  endfunction

  // Memory: acks after mem_lat wait cycles, applies byte-enabled writes on ack.
  initial begin
    int mcnt = 0;
    logic [31:0] word;
    forever begin
      @(posedge clk);
      #1;
      if (m_req && !mem_never && mcnt == mem_lat) begin
        m_ack = 1'b1;
        if (m_we) begin
          word = mem_peek(m_addr);
          for (int b = 0; b < 4; b++)
            if (m_be[b]) word[8*b +: 8] = m_wdata[8*b +: 8];
          mem[m_addr] = word;
          m_rdata = 32'hBAD0_BAD0;
        end else begin
          m_rdata = mem_peek(m_addr);
        end
        last_ack_addr = m_addr; last_ack_we = m_we;
        last_ack_be = m_be;     last_ack_wdata = m_wdata;
        mcnt = 0;
      end else if (m_req) begin
        m_ack = 1'b0;
        m_rdata = 32'hBAD0_BAD0;
        mcnt++;
      end else begin
        m_ack = mem_spurious;
        m_rdata = mem_spurious ? 32'hFFFF_FFFF : 32'h0;
        mcnt = 0;
      end
    end
  end

  // Scoreboard consumer: every done pulse is compared with the oldest expectation.
  initial begin
    bit prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_done) checkOutput("turnaround_idle", m_req, 0);
      prev_done = i_done | d_done;
      if (i_done | d_done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_port_is_d", d_done, e.is_d);
          checkOutput("done_port_is_i", i_done, !e.is_d);
          checkOutput("done_err", err, e.err);
          if (e.is_d) begin
            checkOutput("d_rdata", d_rdata, e.rdata);
            checkOutput("d_stall_on_done", d_stall, 0);
          end else begin
            checkOutput("i_rdata", i_rdata, e.rdata);
            checkOutput("i_stall_on_done", i_stall, 0);
          end
          if (!e.err) begin
            checkOutput("m_addr", last_ack_addr, e.addr);
            checkOutput("m_we", last_ack_we, e.we);
            checkOutput("m_be", last_ack_be, e.be);
            checkOutput("m_wdata", last_ack_wdata, e.wdata);
          end
        end
      end
    end
  end

  task automatic drive_d(input vec_t v, input int k);
    d_we = v.d_we; d_be = v.d_be;
    d_addr = v.d_base + 32'(4 * k);
    d_wdata = v.wbase + 32'(k);
  endtask

  // Pushes the expected completion order, then holds each port's request until done.
  task automatic applyStimulus(input vec_t v);
    int rd = v.n_d, ri = v.n_i, kd = 0, ki = 0, di = 0, ii = 0, cyc = 0;
    while (rd > 0 || ri > 0) begin
      if (rd > 0 && (!model_last_d || ri == 0)) begin
        exp_q.push_back(d_entry(v.d_we, v.d_be, v.d_base + 32'(4 * kd), v.wbase + 32'(kd)));
        kd++; rd--;
      end else begin
        exp_q.push_back(i_entry(v.i_base + 32'(4 * ki)));
        ki++; ri--;
      end
    end
    mem_lat = v.lat;
    if (v.n_d > 0) begin drive_d(v, 0); d_req = 1'b1; end
    if (v.n_i > 0) begin i_addr = v.i_base; i_req = 1'b1; end
    while ((di < v.n_d || ii < v.n_i) && cyc < 300) begin
      tick();
      cyc++;
      if (d_done && di < v.n_d) begin
        di++;
        if (di < v.n_d) drive_d(v, di);
        else d_req = 1'b0;
      end
      if (i_done && ii < v.n_i) begin
        ii++;
        if (ii < v.n_i) i_addr = v.i_base + 32'(4 * ii);
        else i_req = 1'b0;
      end
    end
    checkOutput("vector_in_budget", 32'(cyc < 300), 1);
    d_req = 1'b0; i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 1'b0; m_ack = 1'b0; m_rdata = 32'h0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0; d_wdata = 32'h0;
    mem[32'h40] = 32'h2008_0005;

    vecs[0] = make_vec(1, 1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 32'h44, 0);
    vecs[1] = make_vec(3, 2, 1'b0, 4'hF, 32'h400, 32'hCAFE_0000, 32'h80, 0);
    vecs[2] = make_vec(1, 0, 1'b1, 4'h3, 32'h500, 32'h1234_5678, 32'h0, 2);
    vecs[3] = make_vec(0, 2, 1'b0, 4'hF, 32'h0,   32'h0,         32'hC0, 1);
    vecs[4] = make_vec(2, 1, 1'b0, 4'h5, 32'h640, 32'h0BAD_F00D, 32'hE0, 3);
    vecs[5] = make_vec(2, 2, 1'b1, 4'hF, 32'h680, 32'h5555_AAAA, 32'h100, 0);
    vecs[6] = make_vec(1, 1, 1'b0, 4'hF, 32'h880, 32'h0,         32'h180, 0);

    // Reset held with a pending data request.
    d_req = 1'b1; d_addr = 32'h200;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_m_req", m_req, 0);
    checkOutput("rst_m_we", m_we, 0);
    checkOutput("rst_m_be", m_be, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_m_wdata", m_wdata, 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_done", {30'h0, i_done, d_done}, 0);
    checkOutput("rst_err", err, 0);
    tick();
    rstn = 1'b1;
    exp_q.push_back(d_entry(1'b0, 4'hF, 32'h200, 32'h0));
    tick();
    @(negedge clk);
    checkOutput("rst_release_m_req", m_req, 1);
    checkOutput("rst_release_m_addr", m_addr, 32'h200);
    tick();
    d_req = 1'b0;

    // Zero-wait fetch: done two cycles after the request.
    tick();
    i_addr = 32'h40; i_req = 1'b1;
    exp_q.push_back(i_entry(32'h40));
    @(negedge clk);
    checkOutput("zw_c0_m_req", m_req, 0);
    tick();
    @(negedge clk);
    checkOutput("zw_c1_m_req", m_req, 1);
    checkOutput("zw_c1_m_addr", m_addr, 32'h40);
    checkOutput("zw_c1_m_be", m_be, 4'hF);
    checkOutput("zw_c1_i_done", i_done, 0);
    tick();
    @(negedge clk);
    checkOutput("zw_c2_i_done", i_done, 1);
    checkOutput("zw_c2_i_rdata", i_rdata, 32'h2008_0005);
    checkOutput("zw_c2_i_stall", i_stall, 0);
    tick();
    i_req = 1'b0;

    for (int n = 0; n < 6; n++) applyStimulus(vecs[n]);

    // Five wait states: memory outputs and stall hold until the ack.
    tick();
    mem_lat = 5;
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h600; d_wdata = 32'h0; d_req = 1'b1;
    exp_q.push_back(d_entry(1'b0, 4'hF, 32'h600, 32'h0));
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      tick();
      @(negedge clk);
      checkOutput("ws_m_req", m_req, 1);
      checkOutput("ws_m_addr", m_addr, 32'h600);
      checkOutput("ws_d_stall", d_stall, 1);
    end
    tick();
    @(negedge clk);
    checkOutput("ws_d_done", d_done, 1);
    checkOutput("ws_d_stall_end", d_stall, 0);
    checkOutput("ws_m_req_end", m_req, 0);
    tick();
    d_req = 1'b0;
    mem_lat = 0;

    // Reset in the middle of a transaction: no done, no err, last_d cleared.
    tick();
    mem_never = 1'b1;
    d_addr = 32'h800; d_req = 1'b1;
    repeat (3) tick();
    rstn = 1'b0; d_req = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("mid_rst_m_req", m_req, 0);
    checkOutput("mid_rst_done", {30'h0, i_done, d_done}, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_i_rdata", i_rdata, 0);
    checkOutput("mid_rst_d_rdata", d_rdata, 0);
    tick();
    rstn = 1'b1; mem_never = 1'b0;
    model_last_d = 1'b0; model_d_rdata = 32'h0;
    tick();
    applyStimulus(vecs[6]);

    // Acks while idle must be ignored.
    tick();
    mem_spurious = 1'b1;
    repeat (4) begin
      tick();
      @(negedge clk);
      checkOutput("spur_done", {30'h0, i_done, d_done}, 0);
      checkOutput("spur_err", err, 0);
    end
    mem_spurious = 1'b0;

    // Never-acknowledged load aborts after TIMEOUT cycles of m_req.
    tick();
    mem_never = 1'b1;
    d_we = 1'b0; d_addr = 32'h700; d_req = 1'b1;
    begin
      exp_t e;
      e.is_d = 1'b1; e.we = 1'b0; e.be = 4'hF; e.addr = 32'h700;
      e.wdata = 32'h0; e.rdata = 32'h0; e.err = 1'b1;
      exp_q.push_back(e);
      model_d_rdata = 32'h0; model_last_d = 1'b1;
    end
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      tick();
      @(negedge clk);
      checkOutput("to_m_req_held", m_req, 1);
      checkOutput("to_err_low", err, 0);
    end
    tick();
    @(negedge clk);
    checkOutput("to_m_req_drop", m_req, 0);
    checkOutput("to_err", err, 1);
    checkOutput("to_d_done", d_done, 1);
    checkOutput("to_d_rdata", d_rdata, 0);
    tick();
    d_req = 1'b0; mem_never = 1'b0;
    applyStimulus(make_vec(0, 1, 1'b0, 4'hF, 32'h0, 32'h0, 32'h1C0, 0));

    repeat (3) tick();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
